// File: rtl/rsr.sv
// -----------------------------------------------------------------------------
// rsr -- UART Receive Shift Register
//
// Purpose:
//   Recovers asynchronous serial frames of the form START(0), DATA_SIZE data
//   bits LSB first, STOP(1). The line is oversampled OVERSAMPLE times per bit
//   using rising edges of sample_tick. Each bit is sampled at its midpoint.
//   Good words are presented with a valid/ack handshake. A STOP bit sampled
//   low is reported as a one-clock frame_err pulse.
//
// Parameters:
//   DATA_SIZE   data bits per frame (default 7)
//   OVERSAMPLE  sample events per bit period, even and >= 4 (default 16)
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   asynchronous, active-high reset
//   rx_i         in   serial line, idle high, asynchronous to clk
//   sample_tick  in   oversample clock; each rising edge is one sample event
//   rx_ack       in   consumer has taken rx_data; clears rx_valid
//   rx_data      out  last good received word
//   rx_valid     out  rx_data holds an unread word
//   rx_busy      out  frame reception in progress
//   frame_err    out  one-clock pulse when the STOP bit is sampled low
//   overrun      out  sticky: a word completed while an unread word was held
//
// Configuration:
//   RSR_OVERRUN_EN  When defined, a word that completes while rx_valid=1 and
//                   rx_ack=0 is discarded and overrun is set until rx_ack or
//                   reset. When undefined, the new word overwrites rx_data
//                   and overrun is tied low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rsr #(
  parameter int DATA_SIZE  = 7,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  input  logic                 sample_tick,
  input  logic                 rx_ack,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  // The start bit is checked half a bit after the falling edge. From then
  // on, every full bit period lands in the middle of the next bit.
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_tick_q;
  state_t               r_state;
  logic [CNT_W-1:0]     r_samp_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DATA_SIZE-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_busy;
  logic                 r_frame_err;

  logic                 w_tick_evt;
  state_t               w_next_state;
  logic [CNT_W-1:0]     w_next_samp;
  logic [IDX_W-1:0]     w_next_idx;
  logic                 w_capture;
  logic                 w_stop_good;
  logic                 w_stop_bad;
  logic                 w_load;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  // The synchronizer presets to the idle level so that reset release never
  // looks like a start bit.
  // NOTE: non-blocking assignments in clocked blocks make every flop sample
  // the pre-edge value of its source, which is what gives two real stages
  // here instead of one collapsed stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_tick_q  <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_tick_q  <= sample_tick;
    end
  end

  // One sample event per rising edge of sample_tick, however long it stays high.
  assign w_tick_evt = sample_tick & ~r_tick_q;

  // ---------------------------------------------------------------------------
  // FSM: state and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_samp_cnt <= '0;
      r_bit_idx  <= '0;
      r_rx_busy  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_samp_cnt <= w_next_samp;
      r_bit_idx  <= w_next_idx;
      // Registered from the next state so rx_busy tracks the state register exactly.
      r_rx_busy  <= (w_next_state != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, counters and sample strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default first, so no path through the case
  // leaves an output unassigned, and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_samp  = r_samp_cnt;
    w_next_idx   = r_bit_idx;
    w_capture    = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;

    if (w_tick_evt) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_next_state = S_START;
            w_next_samp  = '0;
          end
        end

        S_START: begin
          if (r_samp_cnt == MID_CNT) begin
            w_next_samp = '0;
            if (!r_rx_s) begin
              w_next_state = S_DATA;
              w_next_idx   = '0;
            end else begin
              // Line went high again before mid-bit: a glitch, not a start bit.
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_samp = r_samp_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_samp_cnt == END_CNT) begin
            w_next_samp = '0;
            w_capture   = 1'b1;
            if (r_bit_idx == LAST_IDX) begin
              w_next_state = S_STOP;
            end else begin
              w_next_idx = r_bit_idx + 1'b1;
            end
          end else begin
            w_next_samp = r_samp_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_samp_cnt == END_CNT) begin
            // Return to IDLE at mid-stop, so the next start edge is caught
            // even if the transmitter's clock runs slightly fast.
            w_next_samp  = '0;
            w_next_state = S_IDLE;
            if (r_rx_s) begin
              w_stop_good = 1'b1;
            end else begin
              w_stop_bad  = 1'b1;
            end
          end else begin
            w_next_samp = r_samp_cnt + 1'b1;
          end
        end

        default: begin
          w_next_state = S_IDLE;
          w_next_samp  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data shift register
  // ---------------------------------------------------------------------------
  // NOTE: this datapath register has no reset. Every frame writes all
  // DATA_SIZE bits before its STOP sample, so stale contents never reach
  // rx_data.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_shift[r_bit_idx] <= r_rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion, handshake and overrun
  // ---------------------------------------------------------------------------
`ifdef RSR_OVERRUN_EN
  logic r_overrun;
  logic w_overrun_hit;

  // Completion onto an unread, unacknowledged word discards the new word.
  assign w_overrun_hit = w_stop_good & r_rx_valid & ~rx_ack;
  assign w_load        = w_stop_good & ~w_overrun_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_hit) begin
      r_overrun <= 1'b1;
    end else if (rx_ack && r_rx_valid) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  // Without overrun tracking, the newest word always wins.
  assign w_load  = w_stop_good;
  assign overrun = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      // A completion in the same clock as rx_ack takes priority, so the
      // new word is presented instead of being dropped.
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = r_rx_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rsr.sv
// -----------------------------------------------------------------------------
// tb_rsr -- self-checking bench for rsr (DATA_SIZE=7, OVERSAMPLE=16).
// One sample event occurs every 4 clocks, so one bit period is 64 clocks.
// Each frame is started just after a sample event, so the receiver's sampling
// points fall at fixed offsets from the start edge.
// A scoreboard queue holds the words expected on each rising edge of rx_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rsr;

  localparam int DW     = 7;
  localparam int BIT_CLK = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_i;
  logic          sample_tick;
  logic          rx_ack;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  int            n_cmp    = 0;
  int            n_bad    = 0;
  int            ferr_cnt = 0;
  logic [DW-1:0] sb_q[$];
  logic          prev_valid = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          exp_valid;
    int            exp_ferr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  rsr #(
    .DATA_SIZE (DW),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_i),
    .sample_tick(sample_tick),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Sample tick: high for one clock out of every four.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count frame_err cycles and score every newly presented word.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid === 1'b1 && prev_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got word %0h, expected none", rx_data);
      end else begin
        check("sb_word", rx_data, sb_q.pop_front());
      end
    end
    prev_valid <= rx_valid;
  end

  // Return at the negedge that follows a posedge with a sample event.
  task automatic align_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!sample_tick && n < 8);
    @(negedge clk);
  endtask

  // Drive START and the data bits, then set the line to the stop level and
  // return at the start of the stop bit. If abort_bit matches a data bit,
  // reset is asserted halfway through that bit and the task returns early.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int abort_bit);
    align_tick();
    rx_i = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_i = d[i];
      if (i == abort_bit) begin
        repeat (BIT_CLK / 2) @(negedge clk);
        check("busy_mid_frame", rx_busy, 1);
        reset = 1'b1;
        rx_i  = 1'b1;
        #1;
        return;
      end
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_i = stop;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Watchdog: bound the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "time limit reached");
  end

  initial begin
    logic got;

    vecs[0] = '{data: 7'h55, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0, exp_data: 7'h55};
    vecs[1] = '{data: 7'h2A, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1, exp_data: 7'h55};
    vecs[2] = '{data: 7'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0, exp_data: 7'h00};
    vecs[3] = '{data: 7'h01, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0, exp_data: 7'h01};
    vecs[4] = '{data: 7'h40, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0, exp_data: 7'h40};
    vecs[5] = '{data: 7'h6B, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1, exp_data: 7'h40};

    reset  = 1'b1;
    rx_i   = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",    rx_data,   0);
    check("rst_valid",   rx_valid,  0);
    check("rst_busy",    rx_busy,   0);
    check("rst_ferr",    frame_err, 0);
    check("rst_overrun", overrun,   0);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // Table-driven frames: good words acked 3 clocks after rx_valid rises,
    // bad stop bits expected to pulse frame_err once and leave rx_data alone.
    for (int v = 0; v < 6; v++) begin
      ferr_cnt = 0;
      if (vecs[v].stop) sb_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, -1);
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (rx_valid || ferr_cnt != 0) begin
          got = 1'b1;
          break;
        end
      end
      check("frame_event_seen", got, 1);
      if (vecs[v].exp_valid) begin
        repeat (3) @(negedge clk);
        check("valid_held_until_ack", rx_valid, 1);
        pulse_ack();
        check("valid_cleared_by_ack", rx_valid, 0);
      end else begin
        rx_i = 1'b1;
      end
      rx_i = 1'b1;
      repeat (80) @(negedge clk);
      check("vec_ferr_cycles", ferr_cnt,   vecs[v].exp_ferr);
      check("vec_data",        rx_data,    vecs[v].exp_data);
      check("vec_valid_end",   rx_valid,   0);
      check("vec_busy_end",    rx_busy,    0);
      check("vec_sb_drained",  sb_q.size(), 0);
    end

    // False start: line low for 5 sample events only.
    ferr_cnt = 0;
    align_tick();
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    check("false_start_busy", rx_busy, 1);
    rx_i = 1'b1;
    repeat (80) @(negedge clk);
    check("false_start_idle",  rx_busy,  0);
    check("false_start_valid", rx_valid, 0);
    check("false_start_ferr",  ferr_cnt, 0);

    // Two frames without ack.
    sb_q.push_back(7'h11);
    send_frame(7'h11, 1'b1, -1);
    repeat (120) @(negedge clk);
    send_frame(7'h22, 1'b1, -1);
    repeat (120) @(negedge clk);
    check("ovr_valid", rx_valid, 1);
`ifdef RSR_OVERRUN_EN
    check("ovr_data_kept", rx_data, 7'h11);
    check("ovr_flag_set",  overrun, 1);
`else
    check("ovr_data_new",  rx_data, 7'h22);
    check("ovr_flag_zero", overrun, 0);
`endif
    pulse_ack();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_flag",  overrun,  0);
    check("ovr_sb_drained", sb_q.size(), 0);

    // Ack in the exact clock of a completion. With the frame starting after
    // the sample event at clock T0, the STOP sample lands at T0+548.
    sb_q.push_back(7'h33);
    send_frame(7'h33, 1'b1, -1);
    repeat (120) @(negedge clk);
    check("race_pre_valid", rx_valid, 1);
    send_frame(7'h4C, 1'b1, -1);
    repeat (35) @(negedge clk);
    check("race_pre_data", rx_data, 7'h33);
    pulse_ack();
    check("race_valid_kept", rx_valid, 1);
    check("race_data_new",   rx_data,  7'h4C);
    check("race_overrun",    overrun,  0);
    repeat (80) @(negedge clk);

    // Reset during data bit 3, then a clean frame.
    send_frame(7'h5A, 1'b1, 3);
    check("mid_rst_data",    rx_data,   0);
    check("mid_rst_valid",   rx_valid,  0);
    check("mid_rst_busy",    rx_busy,   0);
    check("mid_rst_ferr",    frame_err, 0);
    check("mid_rst_overrun", overrun,   0);
    @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    ferr_cnt = 0;
    sb_q.push_back(7'h7F);
    send_frame(7'h7F, 1'b1, -1);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("post_rst_valid", got, 1);
    check("post_rst_data",  rx_data, 7'h7F);
    pulse_ack();
    repeat (80) @(negedge clk);
    check("post_rst_ferr",   ferr_cnt,    0);
    check("post_rst_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
